// File: rtl/mult_result_accum.sv
// Result accumulator behind the 11x11 Booth multiplier: captures products, restarts the
// multiplier, sums N_ACC products and offers the sum on a valid/ready port.
// Optional build macro MRA_SAT_EN: saturating accumulation instead of wrap-around.
module mult_result_accum #(
    parameter int unsigned N_ACC = 4,
    parameter int unsigned ACC_W = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [21:0]      prod,
    input  logic                    prod_valid,
    output logic                    mult_rst,
    output logic signed [ACC_W-1:0] sum_out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ACC - 1);

    localparam logic [1:0] S_WAIT    = 2'd0;
    localparam logic [1:0] S_RESTART = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;

`ifdef MRA_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    logic [1:0]              state;
    logic [1:0]              state_n;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_d;
    logic                    prev_v;
    logic                    prev_v_d;
    logic signed [ACC_W-1:0] sum_d;
    logic                    out_valid_d;
    logic                    mult_rst_d;
    logic                    capture;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] raw_sum;
    logic signed [ACC_W-1:0] acc_n;

    // Adder: sign-extended product into the running sum, wrap or clamp on overflow
    always_comb begin
        prod_ext = ACC_W'(prod);
        raw_sum  = acc + prod_ext;
        acc_n    = raw_sum;
`ifdef MRA_SAT_EN
        if ((acc[ACC_W-1] == prod_ext[ACC_W-1]) && (raw_sum[ACC_W-1] != acc[ACC_W-1])) begin
            acc_n = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
`endif
    end

    // Next-state and registered-output decode
    always_comb begin
        state_n     = state;
        acc_d       = acc;
        cnt_d       = cnt;
        sum_d       = sum_out;
        out_valid_d = out_valid;
        mult_rst_d  = 1'b0;
        prev_v_d    = prod_valid;
        capture     = (state == S_WAIT) && prod_valid && !prev_v;

        case (state)
            S_WAIT: begin
                if (capture) begin
                    if (cnt == CNT_LAST) begin
                        sum_d       = acc_n;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_n     = S_EMIT;
                    end else begin
                        acc_d      = acc_n;
                        cnt_d      = cnt + CNT_W'(1);
                        state_n    = S_RESTART;
                        mult_rst_d = 1'b1;
                        prev_v_d   = 1'b0;
                    end
                end
            end
            S_RESTART: begin
                state_n = S_WAIT;
            end
            S_EMIT: begin
                // Holding here keeps the multiplier parked in its done state
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_n     = S_RESTART;
                    mult_rst_d  = 1'b1;
                    prev_v_d    = 1'b0;
                end
            end
            default: begin
                state_n     = S_WAIT;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_WAIT;
            acc       <= '0;
            cnt       <= '0;
            prev_v    <= 1'b0;
            sum_out   <= '0;
            out_valid <= 1'b0;
            mult_rst  <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_d;
            cnt       <= cnt_d;
            prev_v    <= prev_v_d;
            sum_out   <= sum_d;
            out_valid <= out_valid_d;
            mult_rst  <= mult_rst_d;
        end
    end

    // The multiplier must never be restarted while a sum is still on offer
    a_no_rst_while_valid: assert property (@(posedge clk) disable iff (reset)
        !(mult_rst && out_valid));

endmodule

// File: tb/tb_mult_result_accum.sv
// Self-checking bench for mult_result_accum: vector table, directed corner sequences and
// randomized products checked against a plain-arithmetic reference model.
module tb_mult_result_accum;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [21:0] prod;
    logic               prod_valid;
    logic               out_ready;

    logic               a_rst, b_rst, c_rst;
    logic signed [25:0] a_sum, c_sum;
    logic signed [21:0] b_sum;
    logic               a_ov, b_ov, c_ov;

    int     tests = 0;
    int     fails = 0;
    int     a_rst_cnt = 0;
    int     c_rst_cnt = 0;
    int     viol = 0;
    bit     mon_en = 1'b1;
    bit     rnd_ready = 1'b0;
    longint exp_q[$];

    always #5 clk = ~clk;

    mult_result_accum #(.N_ACC(4), .ACC_W(26)) dut_a (
        .clk(clk), .reset(reset), .prod(prod), .prod_valid(prod_valid),
        .mult_rst(a_rst), .sum_out(a_sum), .out_valid(a_ov), .out_ready(out_ready));

    mult_result_accum #(.N_ACC(4), .ACC_W(22)) dut_b (
        .clk(clk), .reset(reset), .prod(prod), .prod_valid(prod_valid),
        .mult_rst(b_rst), .sum_out(b_sum), .out_valid(b_ov), .out_ready(out_ready));

    mult_result_accum #(.N_ACC(1), .ACC_W(26)) dut_c (
        .clk(clk), .reset(reset), .prod(prod), .prod_valid(prod_valid),
        .mult_rst(c_rst), .sum_out(c_sum), .out_valid(c_ov), .out_ready(out_ready));

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: scoreboard on accepted words, pulse counters, restart-vs-valid invariant
    always begin
        @(negedge clk);
        #1;
        if (a_rst) a_rst_cnt++;
        if (c_rst) c_rst_cnt++;
        if (a_rst && a_ov) viol++;
        if (mon_en && !reset && a_ov && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %0d, expected no word", a_sum);
            end else begin
                check("sum_out", longint'(a_sum), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((a_ov || a_rst) && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) check("idle_timeout", 1, 0);
    endtask

    task automatic send(input longint p, input int hold, input int gap);
        wait_idle();
        prod = 22'(p);
        prod_valid = 1'b1;
        repeat (hold) tick();
        prod_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // Final product of a word: out_valid must be up right after the capturing edge
    task automatic send_last(input longint p);
        wait_idle();
        prod = 22'(p);
        prod_valid = 1'b1;
        tick();
        check("latency_out_valid", a_ov, 1);
        prod_valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        prod_valid = 1'b0;
        tick();
        check("in_reset_valid", a_ov, 0);
        check("in_reset_sum", a_sum, 0);
        check("in_reset_mrst", a_rst, 0);
        reset = 1'b0;
        tick();
        check("post_reset_valid", a_ov, 0);
        check("post_reset_sum", a_sum, 0);
        check("post_reset_mrst", a_rst, 0);
    endtask

    typedef struct {
        longint p0, p1, p2, p3;
        longint exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int     base;
        longint m_acc;
        int     m_cnt;
        int     k;
        longint mm, rr;

        tbl[0] = '{100, -50, 7, 1, 58};
        tbl[1] = '{-1, -1, -1, -1, -4};
        tbl[2] = '{2097151, 2097151, 2097151, 2097151, 8388604};
        tbl[3] = '{-2097152, -2097152, -2097152, -2097152, -8388608};
        tbl[4] = '{0, 0, 0, 0, 0};
        tbl[5] = '{123456, -123456, 999, -1000, -1};

        reset = 1'b1;
        prod = '0;
        prod_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        check("reset_valid", a_ov, 0);
        check("reset_sum", a_sum, 0);
        check("reset_mrst", a_rst, 0);
        reset = 1'b0;
        tick();

        // Vector table: four products per word, sink always ready
        for (int i = 0; i < 6; i++) begin
            base = a_rst_cnt;
            exp_q.push_back(tbl[i].exp);
            send(tbl[i].p0, 1, 1);
            send(tbl[i].p1, 1, 1);
            send(tbl[i].p2, 1, 1);
            send_last(tbl[i].p3);
            check("valid_one_cycle", a_ov, 0);
            check("mrst_after_accept", a_rst, 1);
            tick();
            check("mrst_pulses", a_rst_cnt - base, 4);
        end

        // Backpressure: word held, no restart until accepted
        out_ready = 1'b0;
        exp_q.push_back(100);
        send(10, 1, 1);
        send(20, 1, 1);
        send(30, 1, 1);
        wait_idle();
        prod = 22'(40);
        prod_valid = 1'b1;
        tick();
        check("bp_latency", a_ov, 1);
        prod_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_held", a_ov, 1);
            check("bp_sum_held", a_sum, 100);
            check("bp_no_mrst", a_rst, 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_valid_drop", a_ov, 0);
        check("bp_mrst", a_rst, 1);
        tick();
        check("bp_mrst_single", a_rst, 0);

        // Held valid: one long high level counts as one product
        exp_q.push_back(11);
        send(5, 10, 2);
        send(1, 1, 1);
        send(2, 1, 1);
        send_last(3);
        tick();

        // Reset mid-word discards the partial sum
        send(300, 1, 1);
        send(300, 1, 1);
        do_reset();
        exp_q.push_back(40);
        send(10, 1, 1);
        send(10, 1, 1);
        send(10, 1, 1);
        send_last(10);
        tick();

        // Random products and random sink readiness against the reference model
        rnd_ready = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            logic signed [21:0] rp;
            rp = 22'($urandom);
            m_acc += longint'(rp);
            m_cnt++;
            if (m_cnt == 4) begin
                exp_q.push_back(m_acc);
                m_acc = 0;
                m_cnt = 0;
            end
            send(longint'(rp), $urandom_range(1, 3), $urandom_range(1, 3));
        end
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        check("rand_drained", exp_q.size(), 0);
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        tick();
        mon_en = 1'b0;

        // Overflow on the 22-bit accumulator instance
        do_reset();
        for (int s = 0; s < 2; s++) begin
            longint p;
            longint e;
            p = (s == 0) ? 1048576 : -1048576;
`ifdef MRA_SAT_EN
            e = (s == 0) ? 2097151 : -2097152;
`else
            e = 0;
`endif
            send(p, 1, 1);
            send(p, 1, 1);
            send(p, 1, 1);
            wait_idle();
            prod = 22'(p);
            prod_valid = 1'b1;
            tick();
            check("ovf_valid", b_ov, 1);
            check("ovf_sum", b_sum, e);
            prod_valid = 1'b0;
            tick();
            tick();
        end

        // Single-product words with a multiplier that sits in its done state
        do_reset();
        out_ready = 1'b0;
        base = c_rst_cnt;
        mm = -1024;
        rr = -1024;
        prod = 22'(mm * rr);
        repeat (3) tick();
        prod_valid = 1'b1;
        tick();
        check("n1_valid", c_ov, 1);
        check("n1_sum", c_sum, 1048576);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("n1_hold_no_mrst", c_rst, 0);
            check("n1_hold_valid", c_ov, 1);
        end
        out_ready = 1'b1;
        tick();
        check("n1_valid_drop", c_ov, 0);
        check("n1_mrst", c_rst, 1);
        prod_valid = 1'b0;
        tick();
        check("n1_mrst_single", c_rst, 0);
        check("n1_mrst_count", c_rst_cnt - base, 1);

        check("mrst_with_valid", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
